t_coef_sequencer: RTL and testbench

Drives the T-matrix coefficient ROM (64 × 32-bit IEEE-754, 6-bit address, 1-cycle registered read gated by a read enable) and streams coefficients to the downstream floating-point MAC for one 8×8 matrix product. Loops are ordered i (outer), j, k (inner), giving 512 beats per block. Each beat carries its (i, j, k) tags and dot-product and block boundary flags. The ROM read latency is hidden behind a 2-entry output buffer with credit control, so the stream sustains 1 beat/cycle under continuous ready and stalls losslessly under backpressure.

---
 rtl/t_coef_sequencer.sv | 212 +++++++++++++++++++++
 tb/tb_t_coef_sequencer.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/t_coef_sequencer.sv
// T-matrix coefficient sequencer: walks the i/j/k loops of one 8x8 product,
// reads the coefficient ROM and streams tagged beats through a 2-entry credit buffer.

module t_coef_sequencer_chk (
    input logic       clk_i,
    input logic       rst_i,
    input logic [1:0] occ,
    input logic       inflight,
    input logic       push,
    input logic       pop
);

    a_occ_range: assert property (@(posedge clk_i) disable iff (rst_i)
        occ <= 2'd2);

    a_credit_bound: assert property (@(posedge clk_i) disable iff (rst_i)
        ({1'b0, occ} + {2'b00, inflight}) <= 3'd2);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && (occ == 2'd2)));

endmodule

module t_coef_sequencer (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic        transpose_i,
    output logic        rom_rd_o,
    output logic [5:0]  rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] coef_o,
    output logic        coef_valid_o,
    input  logic        coef_ready_i,
    output logic [2:0]  row_o,
    output logic [2:0]  col_o,
    output logic [2:0]  k_o,
    output logic        dot_last_o,
    output logic        block_last_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] coef;
        logic [2:0]  row;
        logic [2:0]  col;
        logic [2:0]  k;
    } beat_t;

    state_t      state_r;
    state_t      state_nxt_s;
    logic        done_r;
    logic        transpose_r;
    logic [8:0]  iss_idx_r;      // {i, j, k} of the next read to issue
    logic        iss_done_r;
    logic        inflight_r;
    logic [8:0]  shadow_idx_r;   // tags of the read whose data arrives this cycle
    beat_t       ent0_r;
    beat_t       ent1_r;
    logic [1:0]  occ_r;

    logic        start_s;
    logic        pop_s;
    logic        push_s;
    logic        issue_s;
    logic        head_last_s;
    logic        pass_end_s;
    logic [2:0]  credit_s;
    beat_t       push_beat_s;

    // Handshake, credit and issue decode
    always_comb begin
        start_s     = (state_r == ST_IDLE) && start_i;
        pop_s       = (occ_r != 2'd0) && coef_ready_i;
        push_s      = inflight_r;
        head_last_s = (ent0_r.row == 3'd7) && (ent0_r.col == 3'd7) && (ent0_r.k == 3'd7);
        // entries the buffer will hold next cycle if nothing new is issued
        credit_s    = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
        issue_s     = (state_r == ST_RUN) && !iss_done_r && (credit_s < 3'd2);
        push_beat_s = {rom_data_i, shadow_idx_r};
    end

    // Next-state logic of the pass controller
    always_comb begin
        state_nxt_s = state_r;
        pass_end_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start_i) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (pop_s && head_last_s) begin
                    state_nxt_s = ST_IDLE;
                    pass_end_s  = 1'b1;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                pass_end_s  = 1'b0;
            end
        endcase
    end

    // Pass controller state and completion pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_r <= ST_IDLE;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            done_r  <= pass_end_s;
        end
    end

    // Issue counters; the 9-bit index wraps to zero after the final read
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            transpose_r <= 1'b0;
            iss_idx_r   <= 9'd0;
            iss_done_r  <= 1'b0;
        end else if (start_s) begin
            transpose_r <= transpose_i;
            iss_idx_r   <= 9'd0;
            iss_done_r  <= 1'b0;
        end else if (issue_s) begin
            iss_idx_r   <= iss_idx_r + 9'd1;
            iss_done_r  <= (iss_idx_r == 9'h1FF);
        end
    end

    // In-flight flag and tag shadow matching the ROM's one-cycle latency
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            inflight_r   <= 1'b0;
            shadow_idx_r <= 9'd0;
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                shadow_idx_r <= iss_idx_r;
            end
        end
    end

    // Two-entry output buffer; ent0_r is always the head
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ent0_r <= '0;
            ent1_r <= '0;
            occ_r  <= 2'd0;
        end else begin
            case ({push_s, pop_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        ent0_r <= push_beat_s;
                    end else begin
                        ent1_r <= push_beat_s;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    ent0_r <= ent1_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        ent0_r <= push_beat_s;
                    end else begin
                        ent0_r <= ent1_r;
                        ent1_r <= push_beat_s;
                    end
                end
                default: begin
                    occ_r <= occ_r;
                end
            endcase
        end
    end

    assign rom_rd_o     = issue_s;
    assign rom_addr_o   = transpose_r ? iss_idx_r[5:0] : {iss_idx_r[8:6], iss_idx_r[2:0]};
    assign coef_valid_o = (occ_r != 2'd0);
    assign coef_o       = ent0_r.coef;
    assign row_o        = ent0_r.row;
    assign col_o        = ent0_r.col;
    assign k_o          = ent0_r.k;
    assign dot_last_o   = coef_valid_o && (ent0_r.k == 3'd7);
    assign block_last_o = coef_valid_o && head_last_s;
    assign busy_o       = (state_r == ST_RUN);
    assign done_o       = done_r;

    t_coef_sequencer_chk u_chk (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .occ      (occ_r),
        .inflight (inflight_r),
        .push     (push_s),
        .pop      (pop_s)
    );

endmodule

// File: tb/tb_t_coef_sequencer.sv
// Self-checking bench for t_coef_sequencer: a ROM model, randomized ready and
// a loop-order reference model of the 512-beat coefficient stream.

module tb_t_coef_sequencer;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        start_i;
    logic        transpose_i;
    logic        rom_rd_o;
    logic [5:0]  rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] coef_o;
    logic        coef_valid_o;
    logic        coef_ready_i;
    logic [2:0]  row_o;
    logic [2:0]  col_o;
    logic [2:0]  k_o;
    logic        dot_last_o;
    logic        block_last_o;
    logic        busy_o;
    logic        done_o;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] rom [64];
    logic [31:0] cap_coef [$];
    logic [10:0] cap_tag [$];
    logic [5:0]  rd_addr [$];
    logic [31:0] exp_coef [$];
    logic [10:0] exp_tag [$];
    logic [5:0]  exp_addr [$];

    int first_rd, first_valid, done_cyc, busy1, busy_at_done;
    int credit_viol, stable_viol, gap_cnt, reads_at_stall;

    t_coef_sequencer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .transpose_i  (transpose_i),
        .rom_rd_o     (rom_rd_o),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
        .coef_o       (coef_o),
        .coef_valid_o (coef_valid_o),
        .coef_ready_i (coef_ready_i),
        .row_o        (row_o),
        .col_o        (col_o),
        .k_o          (k_o),
        .dot_last_o   (dot_last_o),
        .block_last_o (block_last_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk_i = ~clk_i;

    // ROM model: registered read; garbage whenever no read was issued
    always @(posedge clk_i) begin
        if (rom_rd_o) rom_data_i <= rom[rom_addr_o];
        else          rom_data_i <= $urandom;
    end

    task automatic build_ref(input bit tp);
        exp_coef.delete(); exp_tag.delete(); exp_addr.delete();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                for (int k = 0; k < 8; k++) begin
                    int a;
                    a = tp ? (j * 8 + k) : (i * 8 + k);
                    exp_addr.push_back(6'(a));
                    exp_coef.push_back(rom[a]);
                    exp_tag.push_back({3'(i), 3'(j), 3'(k), k == 7, (i == 7) && (j == 7) && (k == 7)});
                end
    endtask

    // mode 0: ready=1, 1: random ready, 2: ready=0 for 20 cycles after first valid
    task automatic run_pass(input bit tp, input int mode, input bit presented,
                            input bit chain, input bit mid_start);
        int reads = 0;
        int pops = 0;
        bit fin = 1'b0;
        bit prev_hold = 1'b0;
        logic [31:0] prev_coef = '0;
        logic [8:0] prev_tag = '0;
        logic pop_now;
        cap_coef.delete(); cap_tag.delete(); rd_addr.delete();
        first_rd = -1; first_valid = -1; done_cyc = -1; busy1 = -1; busy_at_done = -1;
        credit_viol = 0; stable_viol = 0; gap_cnt = 0; reads_at_stall = -1;
        for (int cyc = presented ? 1 : 0; cyc < 4000 && !fin; cyc++) begin
            @(negedge clk_i);
            if (coef_valid_o && first_valid < 0) first_valid = cyc;
            start_i = (cyc == 0) || (mid_start && cyc == 60) || (chain && done_o);
            transpose_i = ((cyc == 0) || (chain && done_o)) ? tp : 1'($urandom);
            case (mode)
                1:       coef_ready_i = 1'($urandom);
                2:       coef_ready_i = !(first_valid >= 0 && cyc < first_valid + 20);
                default: coef_ready_i = 1'b1;
            endcase
            #1;
            pop_now = coef_valid_o & coef_ready_i;
            if (prev_hold && (!coef_valid_o || coef_o !== prev_coef || {row_o, col_o, k_o} !== prev_tag))
                stable_viol++;
            if ((reads - pops - int'(pop_now) + int'(rom_rd_o)) > 2) credit_viol++;
            if (rom_rd_o) begin
                rd_addr.push_back(rom_addr_o);
                reads++;
                if (first_rd < 0) first_rd = cyc;
            end
            if (mode == 2 && first_valid >= 0 && cyc == first_valid + 19) reads_at_stall = reads;
            if (coef_ready_i && !pop_now && pops > 0 && pops < 512) gap_cnt++;
            if (pop_now) begin
                cap_coef.push_back(coef_o);
                cap_tag.push_back({row_o, col_o, k_o, dot_last_o, block_last_o});
                pops++;
            end
            prev_hold = coef_valid_o && !coef_ready_i;
            prev_coef = coef_o;
            prev_tag  = {row_o, col_o, k_o};
            if (cyc == 1) busy1 = int'(busy_o);
            if (done_o) begin
                done_cyc = cyc;
                busy_at_done = int'(busy_o);
                fin = 1'b1;
            end
        end
        n_cmp++;
        if (!fin) begin
            n_bad++;
            $display("FAIL pass_timeout: got %0d beats and no done_o, want done_o within 4000 cycles", pops);
        end
    endtask

    task automatic test_reset;
        rst_i = 1'b1; start_i = 1'b0; transpose_i = 1'b0; coef_ready_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        n_cmp++;
        if ({rom_rd_o, coef_valid_o, dot_last_o, block_last_o, busy_o, done_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_flags: got %b, want 000000",
                     {rom_rd_o, coef_valid_o, dot_last_o, block_last_o, busy_o, done_o});
        end
        n_cmp++;
        if (rom_addr_o !== 6'd0) begin n_bad++; $display("FAIL reset_addr: got %0d, want 0", rom_addr_o); end
        n_cmp++;
        if (coef_o !== 32'd0) begin n_bad++; $display("FAIL reset_coef: got %h, want 0", coef_o); end
        n_cmp++;
        if ({row_o, col_o, k_o} !== 9'd0) begin
            n_bad++; $display("FAIL reset_tags: got %h, want 0", {row_o, col_o, k_o});
        end
    endtask

    task automatic test_normal;
        int bad = -1;
        build_ref(1'b0);
        run_pass(1'b0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (cap_coef.size() != 512) begin n_bad++; $display("FAIL norm_count: got %0d, want 512", cap_coef.size()); end
        for (int b = 0; b < cap_coef.size() && b < 512; b++)
            if (bad < 0 && {cap_coef[b], cap_tag[b]} !== {exp_coef[b], exp_tag[b]}) bad = b;
        n_cmp++;
        if (bad >= 0) begin
            n_bad++;
            $display("FAIL norm_seq beat %0d: got %h/%h, want %h/%h", bad, cap_coef[bad], cap_tag[bad], exp_coef[bad], exp_tag[bad]);
        end
        n_cmp++;
        if (cap_coef.size() < 10 || cap_coef[0] !== 32'h3DFFCB92 || cap_coef[1] !== 32'h3E34F0D8 || cap_coef[9] !== 32'h3E34F0D8) begin
            n_bad++; $display("FAIL norm_known_coefs: beats 0/1/9 differ from 3DFFCB92/3E34F0D8/3E34F0D8");
        end
        n_cmp++;
        if (rd_addr.size() < 10 || rd_addr[0] !== 6'd0 || rd_addr[9] !== 6'd1) begin
            n_bad++; $display("FAIL norm_addr: beat 0/9 addresses differ from 0/1");
        end
        n_cmp++;
        if (first_rd != 1 || first_valid != 3) begin
            n_bad++; $display("FAIL norm_latency: got rd@%0d valid@%0d, want rd@1 valid@3", first_rd, first_valid);
        end
        n_cmp++;
        if (busy1 != 1 || done_cyc != 515 || busy_at_done != 0) begin
            n_bad++; $display("FAIL norm_done: got busy1=%0d done@%0d busy@done=%0d, want 1/515/0", busy1, done_cyc, busy_at_done);
        end
        n_cmp++;
        if (gap_cnt != 0) begin n_bad++; $display("FAIL norm_gaps: got %0d bubbles, want 0", gap_cnt); end
    endtask

    task automatic test_transpose;
        int bad = -1;
        int nlast = 0;
        build_ref(1'b1);
        run_pass(1'b1, 0, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < cap_coef.size() && b < 512 && b < rd_addr.size(); b++) begin
            if (bad < 0 && {cap_coef[b], cap_tag[b], rd_addr[b]} !== {exp_coef[b], exp_tag[b], exp_addr[b]}) bad = b;
            if (cap_tag[b][0]) nlast++;
        end
        n_cmp++;
        if (bad >= 0 || cap_coef.size() != 512) begin
            n_bad++; $display("FAIL tp_seq: got first diff at beat %0d of %0d beats, want none of 512", bad, cap_coef.size());
        end
        n_cmp++;
        if (cap_coef.size() < 512 || cap_coef[9] !== 32'h3E800000 || rd_addr[8] !== 6'd8 || rd_addr[15] !== 6'd15) begin
            n_bad++; $display("FAIL tp_known: beat 9 coef/addresses 8..15 differ from 3E800000/8..15");
        end
        n_cmp++;
        if (nlast != 1 || cap_tag.size() < 512 || cap_tag[511][0] !== 1'b1 || rd_addr[511] !== 6'd63) begin
            n_bad++; $display("FAIL tp_block_last: got %0d flagged beats, want exactly beat 511 at addr 63", nlast);
        end
    endtask

    task automatic test_random_ready;
        int bad = -1;
        build_ref(1'b0);
        run_pass(1'b0, 1, 1'b0, 1'b0, 1'b0);
        for (int b = 0; b < cap_coef.size() && b < 512; b++)
            if (bad < 0 && {cap_coef[b], cap_tag[b]} !== {exp_coef[b], exp_tag[b]}) bad = b;
        n_cmp++;
        if (bad >= 0 || cap_coef.size() != 512) begin
            n_bad++; $display("FAIL rand_seq: got first diff at beat %0d of %0d beats, want none of 512", bad, cap_coef.size());
        end
        n_cmp++;
        if (credit_viol != 0) begin n_bad++; $display("FAIL rand_credit: got %0d overcommits, want 0", credit_viol); end
        n_cmp++;
        if (stable_viol != 0) begin n_bad++; $display("FAIL rand_stable: got %0d unstable stalls, want 0", stable_viol); end
    endtask

    task automatic test_backpressure;
        int bad = -1;
        build_ref(1'b0);
        run_pass(1'b0, 2, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (reads_at_stall != 2) begin n_bad++; $display("FAIL bp_reads: got %0d reads during stall, want 2", reads_at_stall); end
        for (int b = 0; b < cap_coef.size() && b < 512; b++)
            if (bad < 0 && {cap_coef[b], cap_tag[b]} !== {exp_coef[b], exp_tag[b]}) bad = b;
        n_cmp++;
        if (bad >= 0 || cap_coef.size() != 512) begin
            n_bad++; $display("FAIL bp_seq: got first diff at beat %0d of %0d beats, want none of 512", bad, cap_coef.size());
        end
        n_cmp++;
        if (gap_cnt != 0 || stable_viol != 0 || credit_viol != 0) begin
            n_bad++; $display("FAIL bp_flow: got gaps=%0d unstable=%0d overcommit=%0d, want 0/0/0", gap_cnt, stable_viol, credit_viol);
        end
    endtask

    task automatic test_reset_mid_pass;
        int beats = 0;
        bit hit = 1'b0;
        for (int cyc = 0; cyc < 400 && !hit; cyc++) begin
            @(negedge clk_i);
            start_i = (cyc == 0); transpose_i = 1'b0; coef_ready_i = 1'b1;
            #1;
            if (coef_valid_o && beats == 100) begin
                hit = 1'b1;
                rst_i = 1'b1;
            end else if (coef_valid_o) begin
                beats++;
            end
        end
        @(negedge clk_i);
        rst_i = 1'b0; start_i = 1'b0;
        #1;
        n_cmp++;
        if (!hit || {rom_rd_o, coef_valid_o, dot_last_o, block_last_o, busy_o, done_o} !== 6'b0) begin
            n_bad++;
            $display("FAIL rst_mid_flags: got %b (hit=%0d), want 000000",
                     {rom_rd_o, coef_valid_o, dot_last_o, block_last_o, busy_o, done_o}, hit);
        end
        n_cmp++;
        if ({coef_o, row_o, col_o, k_o, rom_addr_o} !== 47'd0) begin
            n_bad++; $display("FAIL rst_mid_data: got coef=%h tags=%h addr=%0d, want zeros", coef_o, {row_o, col_o, k_o}, rom_addr_o);
        end
        run_pass(1'b0, 0, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (cap_coef.size() != 512 || cap_coef[0] !== 32'h3DFFCB92 || first_valid != 3) begin
            n_bad++; $display("FAIL rst_restart: got %0d beats valid@%0d, want 512 beats, beat0 3DFFCB92 at 3", cap_coef.size(), first_valid);
        end
    endtask

    task automatic test_start_during_run;
        int bad = -1;
        build_ref(1'b1);
        run_pass(1'b1, 0, 1'b0, 1'b0, 1'b1);
        for (int b = 0; b < cap_coef.size() && b < 512; b++)
            if (bad < 0 && {cap_coef[b], cap_tag[b]} !== {exp_coef[b], exp_tag[b]}) bad = b;
        n_cmp++;
        if (bad >= 0 || cap_coef.size() != 512 || done_cyc != 515) begin
            n_bad++; $display("FAIL mid_start: got %0d beats diff@%0d done@%0d, want 512/none/515", cap_coef.size(), bad, done_cyc);
        end
    endtask

    task automatic test_start_in_done;
        int bad = -1;
        run_pass(1'b0, 0, 1'b0, 1'b1, 1'b0);
        build_ref(1'b0);
        run_pass(1'b0, 0, 1'b1, 1'b0, 1'b0);
        for (int b = 0; b < cap_coef.size() && b < 512; b++)
            if (bad < 0 && {cap_coef[b], cap_tag[b]} !== {exp_coef[b], exp_tag[b]}) bad = b;
        n_cmp++;
        if (bad >= 0 || cap_coef.size() != 512) begin
            n_bad++; $display("FAIL chain_seq: got %0d beats diff@%0d, want 512/none", cap_coef.size(), bad);
        end
        n_cmp++;
        if (busy1 != 1 || first_valid != 3 || done_cyc != 515) begin
            n_bad++; $display("FAIL chain_timing: got busy1=%0d valid@%0d done@%0d, want 1/3/515", busy1, first_valid, done_cyc);
        end
    endtask

    initial begin
        rst_i = 1'b1; start_i = 1'b0; transpose_i = 1'b0; coef_ready_i = 1'b0;
        for (int a = 0; a < 64; a++) rom[a] = $urandom;
        rom[0] = 32'h3DFFCB92;
        rom[1] = 32'h3E34F0D8;
        rom[9] = 32'h3E800000;
        test_reset();
        test_normal();
        test_transpose();
        test_random_ready();
        test_backpressure();
        test_reset_mid_pass();
        test_start_during_run();
        test_start_in_done();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
